tx_serial_7o1: RTL and testbench

UART-style asynchronous serial transmitter that consumes the one-cycle start pulse produced by the edge detector on the `partida` button path and sends one 7-bit ASCII character per pulse. Frame format 7O1: one start bit, 7 data bits LSB first, one odd-parity bit, one stop bit. The block sits between the edge detector and the board's serial TX pin, and reports completion with a one-cycle `pronto` pulse.

---
 rtl/tx_serial_7o1.sv | 86 ++++++++
 tb/tb_tx_serial_7o1.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/tx_serial_7o1.sv
// 7O1 UART transmitter: start, 7 data bits LSB first, odd parity, stop.
// Define TX_SERIAL_TWO_STOP_EN for a second stop bit (11-bit frame).
module tx_serial_7o1 #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       partida,
    input  logic [6:0] dados_ascii,
    output logic       saida_serial,
    output logic       ocupado,
    output logic       pronto
);

`ifdef TX_SERIAL_TWO_STOP_EN
    localparam int FRAME_LEN = 11;
`else
    localparam int FRAME_LEN = 10;
`endif
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(FRAME_LEN + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t               state, state_nx;
    logic [FRAME_LEN-1:0] shreg;
    logic [TW-1:0]        tick;
    logic [BW-1:0]        bitcnt;
    logic                 load, tick_tc, last_bit, parity;
    logic [FRAME_LEN-1:0] frame;

    assign parity   = ~^dados_ascii;
    assign tick_tc  = (tick == TW'(CLKS_PER_BIT - 1));
    assign last_bit = (bitcnt == BW'(FRAME_LEN - 1));

`ifdef TX_SERIAL_TWO_STOP_EN
    assign frame = {2'b11, parity, dados_ascii, 1'b0};
`else
    assign frame = {1'b1, parity, dados_ascii, 1'b0};
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        case (state)
            IDLE:  if (partida) begin
                       load     = 1'b1;
                       state_nx = SHIFT;
                   end
            SHIFT: if (tick_tc && last_bit) state_nx = DONE;
            DONE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Shifting in ones keeps the line high once the stop bit has gone out.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shreg  <= '1;
            tick   <= '0;
            bitcnt <= '0;
        end else if (load) begin
            shreg  <= frame;
            tick   <= '0;
            bitcnt <= '0;
        end else if (state == SHIFT) begin
            if (tick_tc) begin
                shreg  <= {1'b1, shreg[FRAME_LEN-1:1]};
                bitcnt <= bitcnt + BW'(1);
                tick   <= '0;
            end else begin
                tick   <= tick + TW'(1);
            end
        end
    end

    assign saida_serial = shreg[0];
    assign ocupado      = (state == SHIFT);
    assign pronto       = (state == DONE);

endmodule

// File: tb/tb_tx_serial_7o1.sv
// Bench for tx_serial_7o1: frame-index reference model checked every cycle,
// plus directed frames checked against hand-written bit patterns.
module tb_tx_serial_7o1;
    localparam int CPB = 4;
`ifdef TX_SERIAL_TWO_STOP_EN
    localparam int FL = 11;
`else
    localparam int FL = 10;
`endif

    logic       clock, reset, partida;
    logic [6:0] dados_ascii;
    logic       saida_serial, ocupado, pronto;
    int         n_cmp = 0, n_bad = 0;

    tx_serial_7o1 #(.CLKS_PER_BIT(CPB)) dut (
        .clock(clock), .reset(reset), .partida(partida), .dados_ascii(dados_ascii),
        .saida_serial(saida_serial), .ocupado(ocupado), .pronto(pronto)
    );

    initial begin
        clock = 0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Line bits in transmit order, parity found by counting ones.
    function automatic logic [10:0] model_frame(input logic [6:0] d);
        int ones = 0;
        for (int i = 0; i < 7; i++) ones += int'(d[i]);
        return {2'b11, (ones % 2 == 0), d, 1'b0};
    endfunction

    // k = cycles since the accepting edge; -1 when the transmitter is free.
    int          k = -1;
    logic [10:0] mbits = '1;

    always @(posedge clock or posedge reset) begin
        if (reset)               k <= -1;
        else if (k < 0) begin
            if (partida) begin
                k     <= 0;
                mbits <= model_frame(dados_ascii);
            end
        end
        else if (k == FL * CPB)  k <= -1;
        else                     k <= k + 1;
    end

    always @(negedge clock) begin
        logic el, eo, ep;
        el = 1'b1; eo = 1'b0; ep = 1'b0;
        if (k >= 0 && k < FL * CPB) begin
            el = mbits[k / CPB];
            eo = 1'b1;
        end else if (k == FL * CPB) begin
            ep = 1'b1;
        end
        chk("cyc_line", int'(saida_serial), int'(el));
        chk("cyc_ocupado", int'(ocupado), int'(eo));
        chk("cyc_pronto", int'(pronto), int'(ep));
    end

    task automatic wait_idle();
        int n = 0;
        while ((ocupado || pronto) && n < 200) begin
            @(negedge clock);
            n++;
        end
        chk("wait_idle_timeout", int'(n < 200), 1);
    endtask

    task automatic send(input logic [6:0] d, input logic [9:0] lit, input string tag);
        logic        ln [0:63];
        logic [10:0] full;
        int          oc_n, pr_n, pr_at;
        full = {1'b1, lit};
        @(negedge clock); partida = 1; dados_ascii = d;
        @(negedge clock); partida = 0;
        oc_n = 0; pr_n = 0; pr_at = -1;
        for (int i = 0; i < FL * CPB + 4; i++) begin
            ln[i] = saida_serial;
            oc_n += int'(ocupado);
            if (pronto) begin
                pr_n++;
                if (pr_at < 0) pr_at = i;
            end
            @(negedge clock);
        end
        for (int b = 0; b < FL; b++)
            for (int j = 0; j < CPB; j++)
                chk($sformatf("%s_bit%0d", tag, b), int'(ln[b*CPB+j]), int'(full[b]));
        chk({tag, "_ocupado_len"}, oc_n, FL * CPB);
        chk({tag, "_pronto_cnt"}, pr_n, 1);
        chk({tag, "_pronto_at"}, pr_at, FL * CPB);
    endtask

    initial begin
        logic [10:0] mf;
        logic        ln [0:127];
        int          oc_n, pr_n;

        reset = 1; partida = 0; dados_ascii = '0;
        #1;
        chk("rst_line", int'(saida_serial), 1);
        chk("rst_ocupado", int'(ocupado), 0);
        chk("rst_pronto", int'(pronto), 0);

        mf = model_frame(7'h41);
        chk("model_41", int'(mf), int'(11'b11110000010));
        mf = model_frame(7'h7F);
        chk("model_7F", int'(mf), int'(11'b11011111110));

        repeat (2) @(negedge clock);
        reset = 0;
        @(negedge clock);

        send(7'h41, 10'b1110000010, "A");
        send(7'h00, 10'b1100000000, "p00");
        send(7'h7F, 10'b1011111110, "p7F");
        send(7'h03, 10'b1100000110, "p03");

        // Retrigger and data change mid-frame must be ignored.
        @(negedge clock); partida = 1; dados_ascii = 7'h55;
        @(negedge clock); partida = 0;
        oc_n = 0;
        for (int i = 0; i < 60; i++) begin
            ln[i] = saida_serial;
            oc_n += int'(ocupado);
            partida = (i == 9);
            if (i == 11) dados_ascii = 7'h2A;
            @(negedge clock);
        end
        mf = {2'b11, 9'b110101010};
        for (int b = 0; b < FL; b++)
            chk($sformatf("ign_bit%0d", b), int'(ln[b*CPB+2]), int'(mf[b]));
        chk("ign_ocupado_len", oc_n, FL * CPB);
        wait_idle();

        // Reset mid-frame at cycle 17.
        @(negedge clock); partida = 1; dados_ascii = 7'h33;
        @(negedge clock); partida = 0;
        repeat (16) @(negedge clock);
        #2 reset = 1;
        #1;
        chk("rstmid_line", int'(saida_serial), 1);
        chk("rstmid_ocupado", int'(ocupado), 0);
        repeat (2) @(negedge clock);
        reset = 0;
        pr_n = 0;
        for (int i = 0; i < 10; i++) begin
            pr_n += int'(pronto);
            @(negedge clock);
        end
        chk("rstmid_no_pronto", pr_n, 0);
        send(7'h41, 10'b1110000010, "postrst");

        // partida held high: back-to-back frames.
        @(negedge clock); partida = 1; dados_ascii = 7'h41;
        @(negedge clock);
        oc_n = 0; pr_n = 0;
        for (int i = 0; i < 2 * (FL * CPB + 2); i++) begin
            ln[i] = saida_serial;
            oc_n += int'(ocupado);
            pr_n += int'(pronto);
            if (i == 2 * (FL * CPB + 2) - 1) partida = 0;
            @(negedge clock);
        end
        chk("cont_ocupado_len", oc_n, 2 * FL * CPB);
        chk("cont_pronto_cnt", pr_n, 2);
        chk("cont_gap_high", int'(ln[FL*CPB+1]), 1);
        chk("cont_f2_start", int'(ln[FL*CPB+2]), 0);
        chk("cont_f2_bit1", int'(ln[FL*CPB+2+CPB]), 1);
        wait_idle();
        repeat (3) @(negedge clock);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected finish");
        $fatal(1);
    end
endmodule
